// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex accumulate/requantize block.
// Provides the FSM state enum, clog2, accumulator width derivation and the
// default 32-bit signed output bounds.
package cplx_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned CPLX_IN_W  = 64;
    localparam int unsigned CPLX_OUT_W = 32;
    localparam int unsigned CPLX_LEN   = 16;
    localparam int unsigned CPLX_SHIFT = 0;

    localparam logic signed [CPLX_OUT_W-1:0] CPLX_OUT_MAX = {1'b0, {(CPLX_OUT_W-1){1'b1}}};
    localparam logic signed [CPLX_OUT_W-1:0] CPLX_OUT_MIN = {1'b1, {(CPLX_OUT_W-1){1'b0}}};

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator wide enough that LEN full-scale samples cannot overflow.
    function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned len);
        return in_w + clog2(len);
    endfunction

endpackage

// File: rtl/cplx_accum_requant_if.sv
// Streaming bus for cplx_accum_requant.
//   in_valid/in_ready/in_re/in_im    : input sample stream (IN_W signed)
//   out_valid/out_ready/out_re/out_im/out_sat : result stream (OUT_W signed)
// slave  = the accumulator block, master = the upstream/downstream driver.
interface cplx_accum_requant_if
    import cplx_pkg::*;
#(
    parameter int unsigned IN_W  = CPLX_IN_W,
    parameter int unsigned OUT_W = CPLX_OUT_W
);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_re;
    logic signed [IN_W-1:0]  in_im;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic                    out_sat;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sat
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sat
    );

endinterface

// File: rtl/round_sat.sv
// Combinational round-half-up by 2^SHIFT followed by saturation to OUT_W signed.
//   i_acc : ACC_W signed accumulator value
//   o_val : OUT_W signed rounded/saturated result
//   o_sat : result was clipped to the OUT_W range
module round_sat #(
    parameter int unsigned ACC_W = 68,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned OUT_W = 32
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    // One guard bit so adding the rounding term can never wrap.
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(0) - (EXT_W'(1) << (OUT_W - 1));

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_bias;
    logic signed [EXT_W-1:0] w_shr;

    assign w_ext = {i_acc[ACC_W-1], i_acc};

    // Half an output LSB; no bias when there is no shift.
    generate
        if (SHIFT == 0) begin : g_bias_none
            assign w_bias = '0;
        end else begin : g_bias_half
            assign w_bias = EXT_W'(1) << (SHIFT - 1);
        end
    endgenerate

    assign w_shr = (w_ext + w_bias) >>> SHIFT;

    // Clip to the OUT_W signed range and flag it.
    always_comb begin
        o_sat = 1'b0;
        o_val = w_shr[OUT_W-1:0];
        if (w_shr > SAT_MAX) begin
            o_val = SAT_MAX[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_shr < SAT_MIN) begin
            o_val = SAT_MIN[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/cplx_accum_requant.sv
// Accumulates LEN complex products into a wide accumulator, then rounds and
// saturates the sum back to OUT_W signed for feedback into the multiplier array.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of cplx_accum_requant_if (input samples, result stream)
module cplx_accum_requant
    import cplx_pkg::*;
#(
    parameter int unsigned LEN   = CPLX_LEN,
    parameter int unsigned SHIFT = CPLX_SHIFT,
    parameter int unsigned IN_W  = CPLX_IN_W,
    parameter int unsigned OUT_W = CPLX_OUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cplx_accum_requant_if.slave  bus
);

    localparam int unsigned ACC_W = acc_w(IN_W, LEN);
    localparam int unsigned CNT_W = clog2(LEN);
    localparam int unsigned EXT_W = ACC_W - IN_W;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_out_sat;
    logic signed [OUT_W-1:0] r_out_re;
    logic signed [OUT_W-1:0] r_out_im;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_load;
    logic                    w_done;
    logic signed [ACC_W-1:0] w_in_re_x;
    logic signed [ACC_W-1:0] w_in_im_x;
    logic signed [OUT_W-1:0] w_rs_re;
    logic signed [OUT_W-1:0] w_rs_im;
    logic                    w_sat_re;
    logic                    w_sat_im;

    assign w_in_re_x = {{EXT_W{bus.in_re[IN_W-1]}}, bus.in_re};
    assign w_in_im_x = {{EXT_W{bus.in_im[IN_W-1]}}, bus.in_im};

    round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_re (
        .i_acc (r_acc_re),
        .o_val (w_rs_re),
        .o_sat (w_sat_re)
    );

    round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_im (
        .i_acc (r_acc_im),
        .o_val (w_rs_im),
        .o_sat (w_sat_im)
    );

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_last      = (r_cnt == CNT_W'(LEN - 1));
        case (r_state)
            ACCUM: begin
                // r_in_ready gates the first cycle after reset.
                w_accept = bus.in_valid && r_in_ready;
                if (w_accept && w_last) begin
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                w_load      = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (r_out_valid && bus.out_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ACCUM);
            if (w_accept) begin
                r_acc_re <= r_acc_re + w_in_re_x;
                r_acc_im <= r_acc_im + w_in_im_x;
                r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_out_re    <= w_rs_re;
                r_out_im    <= w_rs_im;
                r_out_sat   <= w_sat_re | w_sat_im;
                r_out_valid <= 1'b1;
            end
            if (w_done) begin
                r_out_valid <= 1'b0;
                r_acc_re    <= '0;
                r_acc_im    <= '0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_cplx_accum_requant.sv
// Directed bench for cplx_accum_requant: LEN=4/SHIFT=0 (dut_a) and
// LEN=2/SHIFT=4 (dut_b) sharing one clock and reset.
module tb_cplx_accum_requant;
    import cplx_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cplx_accum_requant_if #(.IN_W(64), .OUT_W(32)) bus_a ();
    cplx_accum_requant_if #(.IN_W(64), .OUT_W(32)) bus_b ();

    cplx_accum_requant #(.LEN(4), .SHIFT(0), .IN_W(64), .OUT_W(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    cplx_accum_requant #(.LEN(2), .SHIFT(4), .IN_W(64), .OUT_W(32)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic signed [63:0] re, input logic signed [63:0] im);
        int n;
        n = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_re    = re;
        bus_a.in_im    = im;
        while (!bus_a.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("a_push_timeout", 64'd0, 64'd1);
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic signed [63:0] re, input logic signed [63:0] im);
        int n;
        n = 0;
        bus_b.in_valid = 1'b1;
        bus_b.in_re    = re;
        bus_b.in_im    = im;
        while (!bus_b.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("b_push_timeout", 64'd0, 64'd1);
        tick();
        bus_b.in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(input string tag);
        int n;
        n = 0;
        while (!bus_a.out_valid && n < 10) begin
            tick();
            n++;
        end
        check(tag, 64'(bus_a.out_valid), 64'd1);
    endtask

    task automatic wait_valid_b(input string tag);
        int n;
        n = 0;
        while (!bus_b.out_valid && n < 10) begin
            tick();
            n++;
        end
        check(tag, 64'(bus_b.out_valid), 64'd1);
    endtask

    task automatic handshake_a();
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic handshake_b();
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_re     = '0;
        bus_a.in_im     = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_re     = '0;
        bus_b.in_im     = '0;
        bus_b.out_ready = 1'b0;

        // Reset state
        tick();
        check("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_out_re",    64'(bus_a.out_re),    64'd0);
        check("rst_out_im",    64'(bus_a.out_im),    64'd0);
        check("rst_out_sat",   64'(bus_a.out_sat),   64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);

        // Rounding, LEN=2 SHIFT=4: (24+8)>>4=2, (-24+8)>>4=-1
        push_b(12, -12);
        push_b(12, -12);
        check("rnd1_round_cycle_valid", 64'(bus_b.out_valid), 64'd0);
        tick();
        check("rnd1_valid", 64'(bus_b.out_valid), 64'd1);
        check("rnd1_re",    64'(bus_b.out_re),    64'd2);
        check("rnd1_im",    64'(bus_b.out_im),    -64'sd1);
        check("rnd1_sat",   64'(bus_b.out_sat),   64'd0);
        handshake_b();

        // (8+8)>>4=1; -8 is exactly -0.5 LSB, rounds up to 0
        push_b(4, -4);
        push_b(4, -4);
        wait_valid_b("rnd2_valid");
        check("rnd2_re",  64'(bus_b.out_re),  64'd1);
        check("rnd2_im",  64'(bus_b.out_im),  64'd0);
        check("rnd2_sat", 64'(bus_b.out_sat), 64'd0);
        handshake_b();

        // Basic sum, back-to-back, latency
        push_a(1, -1);
        push_a(2, -2);
        push_a(3, -3);
        push_a(4, -4);
        check("basic_round_valid",    64'(bus_a.out_valid), 64'd0);
        check("basic_round_in_ready", 64'(bus_a.in_ready),  64'd0);
        tick();
        check("basic_valid", 64'(bus_a.out_valid), 64'd1);
        check("basic_re",    64'(bus_a.out_re),    64'd10);
        check("basic_im",    64'(bus_a.out_im),    -64'sd10);
        check("basic_sat",   64'(bus_a.out_sat),   64'd0);
        handshake_a();
        check("basic_hs_valid",    64'(bus_a.out_valid), 64'd0);
        check("basic_hs_in_ready", 64'(bus_a.in_ready),  64'd1);

        // Saturation both directions
        for (int i = 0; i < 4; i++) push_a(64'sh0000_0100_0000_0000, -64'sh0000_0100_0000_0000);
        wait_valid_a("sat_valid");
        check("sat_re",  64'(bus_a.out_re),  64'(CPLX_OUT_MAX));
        check("sat_im",  64'(bus_a.out_im),  64'(CPLX_OUT_MIN));
        check("sat_flag", 64'(bus_a.out_sat), 64'd1);
        handshake_a();

        // Exactly at the range limits: no saturation
        push_a(64'sh1FFF_FFFF, -64'sh2000_0000);
        push_a(64'sh1FFF_FFFF, -64'sh2000_0000);
        push_a(64'sh1FFF_FFFF, -64'sh2000_0000);
        push_a(64'sh2000_0002, -64'sh2000_0000);
        wait_valid_a("edge_valid");
        check("edge_re",  64'(bus_a.out_re),  64'sh7FFF_FFFF);
        check("edge_im",  64'(bus_a.out_im),  -64'sh8000_0000);
        check("edge_sat", 64'(bus_a.out_sat), 64'd0);
        handshake_a();

        // Gaps on input, backpressure on output; stray samples during HOLD ignored
        push_a(5, 100);
        tick();
        push_a(6, -50);
        tick();
        push_a(7, 0);
        tick();
        push_a(8, 7);
        wait_valid_a("bp_valid");
        bus_a.in_valid = 1'b1;
        bus_a.in_re    = 999;
        bus_a.in_im    = 999;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",    64'(bus_a.out_valid), 64'd1);
            check("bp_hold_re",       64'(bus_a.out_re),    64'd26);
            check("bp_hold_im",       64'(bus_a.out_im),    64'd57);
            check("bp_hold_in_ready", 64'(bus_a.in_ready),  64'd0);
            tick();
        end
        bus_a.in_valid = 1'b0;
        handshake_a();
        check("bp_release_in_ready", 64'(bus_a.in_ready),  64'd1);
        check("bp_release_valid",    64'(bus_a.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) push_a(1, 2);
        wait_valid_a("bp2_valid");
        check("bp2_re", 64'(bus_a.out_re), 64'd4);
        check("bp2_im", 64'(bus_a.out_im), 64'd8);
        handshake_a();

        // Reset mid-block discards the partial sum
        push_a(100, 100);
        push_a(100, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_a(1, 0);
        wait_valid_a("mrst_valid");
        check("mrst_re", 64'(bus_a.out_re), 64'd4);
        check("mrst_im", 64'(bus_a.out_im), 64'd0);

        // Reset while holding a pending result
        reset = 1'b1;
        tick();
        check("hrst_valid", 64'(bus_a.out_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("hrst_in_ready", 64'(bus_a.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
